// File: rtl/enigma_rotor_stage.sv
// enigma_rotor_stage: one clocked Enigma rotor with a programmable wiring table,
// position/ring registers, notch carry and a one-entry valid/ready output register.
// Optional build macro ROTOR_DOUBLE_STEP_EN enables the middle-rotor double step
// driven by key_step; with the macro undefined key_step has no effect.
module enigma_rotor_stage #(
  parameter int unsigned  DATA_W    = 8,
  // Rotor I "EKMFLGDQVZNTOWYHXUSPAIBRCJ", entry i at bits [5i+4:5i]
  parameter logic [129:0] WIRING    = {5'd9,  5'd2,  5'd17, 5'd1,  5'd8,  5'd0,
                                       5'd15, 5'd18, 5'd20, 5'd23, 5'd7,  5'd24,
                                       5'd22, 5'd14, 5'd19, 5'd13, 5'd25, 5'd21,
                                       5'd16, 5'd3,  5'd6,  5'd11, 5'd5,  5'd12,
                                       5'd10, 5'd4},
  parameter int unsigned  NOTCH     = 16,
  parameter int unsigned  INIT_POS  = 0,
  parameter int unsigned  INIT_RING = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_char,
  input  logic              in_dir,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_char,
  output logic              out_dir,
  input  logic              step_in,
  input  logic              key_step,
  input  logic              load,
  input  logic [4:0]        load_pos,
  input  logic [4:0]        load_ring,
  output logic [4:0]        position,
  output logic              at_notch,
  output logic              carry_out
);

  localparam logic [4:0] NOTCH_P = 5'(NOTCH);
  localparam logic [4:0] INIT_P  = 5'(INIT_POS);
  localparam logic [4:0] INIT_R  = 5'(INIT_RING);

  logic [4:0]        pos_q, pos_d;
  logic [4:0]        ring_q, ring_d;
  logic              carry_q, carry_d;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_char_q;
  logic              out_dir_q;

  logic              accept;
  logic              do_step;
  logic              is_upper, is_lower;
  logic [DATA_W-1:0] base;
  logic [4:0]        idx, s_idx, w_fwd, w_rev, w_idx, o_idx;
  logic [DATA_W-1:0] xlate;

  // Reduce a 0..77 value into 0..25 with at most two subtractions
  function automatic logic [4:0] mod26(input logic [6:0] v);
    logic [6:0] r;
    r = v;
    if (r >= 7'd26) r = r - 7'd26;
    if (r >= 7'd26) r = r - 7'd26;
    return 5'(r);
  endfunction

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign position  = pos_q;
  assign at_notch  = (pos_q == NOTCH_P);
  assign carry_out = carry_q;
  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;
  assign out_dir   = out_dir_q;

`ifdef ROTOR_DOUBLE_STEP_EN
  assign do_step = step_in || (key_step && at_notch);
`else
  logic unused_key_step;
  assign unused_key_step = key_step;
  assign do_step = step_in;
`endif

  // Letter translation through the rotor using the pre-edge position and ring
  always_comb begin
    is_upper = (in_char >= DATA_W'(65)) && (in_char <= DATA_W'(90));
    is_lower = (in_char >= DATA_W'(97)) && (in_char <= DATA_W'(122));
    base     = is_lower ? DATA_W'(97) : DATA_W'(65);
    idx      = 5'(in_char - base);
    s_idx    = mod26(7'(idx) + 7'(pos_q) + 7'd26 - 7'(ring_q));
    w_fwd    = WIRING[5*s_idx +: 5];
    w_rev    = '0;
    for (int unsigned j = 0; j < 26; j++) begin
      if (WIRING[5*j +: 5] == s_idx) w_rev = 5'(j);
    end
    w_idx    = in_dir ? w_rev : w_fwd;
    o_idx    = mod26(7'(w_idx) + 7'd26 - 7'(pos_q) + 7'(ring_q));
    xlate    = (is_upper || is_lower) ? (base + DATA_W'(o_idx)) : in_char;
  end

  // Next position/ring/carry: load beats step, carry only on a step off the notch
  always_comb begin
    pos_d   = pos_q;
    ring_d  = ring_q;
    carry_d = 1'b0;
    if (load) begin
      pos_d  = (load_pos  >= 5'd26) ? (load_pos  - 5'd26) : load_pos;
      ring_d = (load_ring >= 5'd26) ? (load_ring - 5'd26) : load_ring;
    end else if (do_step) begin
      pos_d   = (pos_q == 5'd25) ? 5'd0 : (pos_q + 5'd1);
      carry_d = (pos_q == NOTCH_P);
    end
  end

  // Rotor state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_q   <= INIT_P;
      ring_q  <= INIT_R;
      carry_q <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      ring_q  <= ring_d;
      carry_q <= carry_d;
    end
  end

  // One-entry output register; holds while stalled by out_ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
      out_dir_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_char_q  <= xlate;
      out_dir_q   <= in_dir;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: doc/enigma_rotor_stage.md
Name: enigma_rotor_stage

Overview:
- Parametrised, clocked successor to the fixed combinational rotor.
- One Enigma rotor stage with:
  - a programmable wiring table
  - a position register and a ring setting
  - a notch carry output
  - forward and reverse translation
  - a valid/ready handshake with a one-entry output register
- Three instances are chained between the plugboard and the reflector. The stepping controller drives step_in; stage-to-stage stepping uses carry_out.

Parameters:
- DATA_W, 8, character width; ASCII letters are case-preserving.
- WIRING, 130 bits, rotor I "EKMFLGDQVZNTOWYHXUSPAIBRCJ"; entry i occupies bits [5i+4:5i], value 0..25.
- NOTCH, 16, position index (Q) at which a step produces carry_out.
- INIT_POS, 0, position loaded at reset.
- INIT_RING, 0, ring setting loaded at reset.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input character valid.
- in_ready  out  1  stage can accept a character.
- in_char  in  DATA_W  input character.
- in_dir  in  1  0 = forward (toward reflector), 1 = reverse.
- out_valid  out  1  output character valid.
- out_ready  in  1  downstream accepts the output.
- out_char  out  DATA_W  translated character.
- out_dir  out  1  in_dir registered with the character.
- step_in  in  1  one-cycle pulse: advance position by 1.
- key_step  in  1  keystroke pulse, used only with ROTOR_DOUBLE_STEP_EN.
- load  in  1  load position and ring.
- load_pos  in  5  new position 0..25.
- load_ring  in  5  new ring setting 0..25.
- position  out  5  current position.
- at_notch  out  1  position == NOTCH.
- carry_out  out  1  registered one-cycle pulse to the next rotor.

Behaviour:
- Reset (rst low, async):
  - position = INIT_POS, ring = INIT_RING.
  - out_valid = 0, out_char = 0, out_dir = 0, carry_out = 0.
  - in_ready = 1 once rst deasserts.
- Handshake:
  - in_ready = !out_valid | out_ready.
  - A character is accepted when in_valid & in_ready.
  - The translated character appears in the output register with out_valid = 1 the next cycle; latency is 1 cycle.
  - Throughput is 1 character per cycle while out_ready = 1.
  - out_valid clears on out_ready when no new accept occurs in that cycle.
  - While out_valid & !out_ready: out_char and out_dir are held stable, and in_ready = 0.
- Translation uses the position register value in the accept cycle (pre-edge). The controller pulses step_in at least 1 cycle before the first character of a keystroke.
- Letter index: idx = in_char - 65 for 'A'..'Z', or in_char - 97 for 'a'..'z'. The output uses the same case base.
- Forward:
  - s = (idx + pos - ring) mod 26
  - w = WIRING[s]
  - out = (w - pos + ring) mod 26
- Reverse:
  - Same as forward, using the inverse table (w = j such that WIRING[j] = s).
  - The inverse may be built at elaboration or searched combinationally.
- Mod-26 arithmetic: intermediates are at least 7 bits. Add 26 before subtracting, then reduce with at most two conditional subtractions of 26. No "%" operator.
- Non-letters (including 0x00 and '?') pass through unchanged; out_dir still follows in_dir.
- Stepping:
  - step_in advances position to (pos + 1) mod 26; 25 wraps to 0.
  - carry_out = 1 for exactly one cycle when a step occurs from pos == NOTCH.
  - No carry on wrap unless NOTCH = 25.
- Priority: load > step.
  - load in the same cycle as step_in: position = load_pos, ring = load_ring, no carry.
  - load values ≥ 26 are reduced by subtracting 26 (so load_pos 31 loads 5).
- load or step in the same cycle as an accept: the accepted character uses the old position; the new position applies from the next accept.
- Reset asserted mid-transfer: the output register is discarded immediately (out_valid = 0). There is no partial-state recovery.

Optional Feature:
- Macro: ROTOR_DOUBLE_STEP_EN.
- Defined: the stage also steps on key_step when at_notch = 1, emitting carry_out. This is the middle-rotor double step.
  - key_step & step_in together cause a single step only.
- Undefined: key_step is ignored and stepping comes only from step_in and load.

Test Plan:
- Reset, pos 0, ring 0, forward 'A' -> 'E' one cycle after accept; forward 'a' -> 'e'; reverse 'E' -> 'A'.
- step_in once (pos 0→1), forward 'A' -> 'J'. Load pos 0, ring 1, forward 'A' -> 'K'.
- load pos 16, step_in -> position 17 and carry_out high exactly 1 cycle. Load pos 25, step_in -> position 0, no carry. load + step_in in the same cycle -> load wins.
- Hold out_ready = 0 while presenting 'A','B' -> out_char 'E' held, in_ready = 0. Release -> 'E' then 'K' on consecutive cycles, no loss or duplication.
- Input '5' and ' ' -> passed through unchanged. Assert rst mid-stream -> out_valid = 0 immediately and position = INIT_POS.
- With ROTOR_DOUBLE_STEP_EN: pos 16, key_step -> pos 17 plus carry. Pos 3, key_step -> no change. Without the macro: pos 16, key_step -> no change.
